// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: source ids, grant-state encoding
// and the default outstanding-transaction depth.
package sram_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam int OT_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        G_FREE = 2'd0,
        G_INST = 2'd1,
        G_DATA = 2'd2
    } grant_state_e;

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// 1-bit order FIFO that records which master issued each accepted transaction so
// that in-order responses can be routed back to that master.
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic              id_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = id_mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store, data first,
// with grant locking and in-order response routing through an order FIFO.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = OT_DEPTH_DEFAULT,
    parameter int CNT_W    = $clog2(OT_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_sram_req,
    input  logic             inst_sram_wr,
    input  logic [1:0]       inst_sram_size,
    input  logic [31:0]      inst_sram_addr,
    input  logic [3:0]       inst_sram_wstrb,
    input  logic [31:0]      inst_sram_wdata,
    output logic             inst_sram_addr_ok,
    output logic             inst_sram_data_ok,
    output logic [31:0]      inst_sram_rdata,
    input  logic             data_sram_req,
    input  logic             data_sram_wr,
    input  logic [1:0]       data_sram_size,
    input  logic [31:0]      data_sram_addr,
    input  logic [3:0]       data_sram_wstrb,
    input  logic [31:0]      data_sram_wdata,
    output logic             data_sram_addr_ok,
    output logic             data_sram_data_ok,
    output logic [31:0]      data_sram_rdata,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] ot_cnt,
    output logic             proto_err
);
    grant_state_e state_reg;
    logic         proto_err_reg;
    logic         src_sel;
    logic         src_req;
    logic         accept;
    logic         fifo_head;
    logic         fifo_full;
    logic         fifo_empty;

    // A locked grant ignores the other master until the held request is taken.
    always_comb begin
        src_sel = SRC_INST;
        src_req = 1'b0;
        case (state_reg)
            G_FREE: begin
                if (data_sram_req) begin
                    src_sel = SRC_DATA;
                    src_req = 1'b1;
                end else if (inst_sram_req) begin
                    src_sel = SRC_INST;
                    src_req = 1'b1;
                end
            end
            G_INST: begin
                src_sel = SRC_INST;
                src_req = inst_sram_req;
            end
            G_DATA: begin
                src_sel = SRC_DATA;
                src_req = data_sram_req;
            end
            default: begin
                src_sel = SRC_INST;
                src_req = 1'b0;
            end
        endcase
    end

    // Full blocks requests on the registered count so data_ok never reaches req.
    assign mem_req   = src_req && !fifo_full;
    assign mem_wr    = (src_sel == SRC_DATA) ? data_sram_wr    : inst_sram_wr;
    assign mem_size  = (src_sel == SRC_DATA) ? data_sram_size  : inst_sram_size;
    assign mem_addr  = (src_sel == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
    assign mem_wstrb = (src_sel == SRC_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    assign mem_wdata = (src_sel == SRC_DATA) ? data_sram_wdata : inst_sram_wdata;

    assign accept            = mem_req && mem_addr_ok;
    assign inst_sram_addr_ok = accept && (src_sel == SRC_INST);
    assign data_sram_addr_ok = accept && (src_sel == SRC_DATA);
    assign inst_sram_data_ok = mem_data_ok && !fifo_empty && (fifo_head == SRC_INST);
    assign data_sram_data_ok = mem_data_ok && !fifo_empty && (fifo_head == SRC_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;
    assign proto_err         = proto_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= G_FREE;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                G_FREE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state_reg <= (src_sel == SRC_DATA) ? G_DATA : G_INST;
                    end
                end
                G_INST, G_DATA: begin
                    if (accept) begin
                        state_reg <= G_FREE;
                    end
                end
                default: state_reg <= G_FREE;
            endcase
            if (mem_data_ok && fifo_empty) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    order_fifo #(
        .DEPTH (OT_DEPTH),
        .CNT_W (CNT_W)
    ) u_order_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (src_sel),
        .pop     (mem_data_ok),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (ot_cnt)
    );

endmodule
